// File: rtl/radix_4_divider_using_controller.sv
// radix_4_divider_using_controller: start/done sequenced radix-4 restoring divider, 2 quotient bits per cycle.
// Define RADIX4_DIV_SIGNED_EN for two's-complement operands (truncation toward zero).
module radix_4_divider_using_controller #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         done,
  output logic         busy,
  output logic         div_by_zero
);
  localparam int CW = $clog2(N/2);
  typedef enum logic [1:0] {IDLE, LOAD, ITER, RESULT} state_t;
  state_t state_q;
  logic [N-1:0] dvd_q, d_q, r_q, q_q, r_d, q_d, a_mag, b_mag, res_q, res_r;
  logic [N+1:0] d3_q, r_sh, sub;
  logic [CW-1:0] cnt_q;
  logic [1:0] qd;
`ifdef RADIX4_DIV_SIGNED_EN
  logic sq_q, sr_q;
  assign a_mag = a_in[N-1] ? ~a_in + 1'b1 : a_in;
  assign b_mag = b_in[N-1] ? ~b_in + 1'b1 : b_in;
  assign res_q = sq_q ? ~q_d + 1'b1 : q_d;
  assign res_r = sr_q ? ~r_d + 1'b1 : r_d;
`else
  assign a_mag = a_in;
  assign b_mag = b_in;
  assign res_q = q_d;
  assign res_r = r_d;
`endif
  assign busy = state_q != IDLE;
  // Partial remainder stays below d, so only N bits are stored; compares use N+2.
  always_comb begin
    r_sh = {r_q, dvd_q[N-1:N-2]};
    qd = r_sh >= d3_q ? 2'd3 : r_sh >= {1'b0, d_q, 1'b0} ? 2'd2 : r_sh >= {2'b0, d_q} ? 2'd1 : 2'd0;
    sub = qd == 2'd3 ? d3_q : qd == 2'd2 ? {1'b0, d_q, 1'b0} : qd == 2'd1 ? {2'b0, d_q} : '0;
    r_d = N'(r_sh - sub);
    q_d = {q_q[N-3:0], qd};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q <= '0;
      d_q <= '0;
      d3_q <= '0;
      r_q <= '0;
      q_q <= '0;
      cnt_q <= '0;
      quotient <= '0;
      remainder <= '0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef RADIX4_DIV_SIGNED_EN
      sq_q <= 1'b0;
      sr_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) state_q <= LOAD;
        LOAD: begin
          dvd_q <= a_mag;
          d_q <= b_mag;
          d3_q <= {2'b0, b_mag} + {1'b0, b_mag, 1'b0};
          r_q <= '0;
          q_q <= '0;
          cnt_q <= '0;
`ifdef RADIX4_DIV_SIGNED_EN
          sq_q <= a_in[N-1] ^ b_in[N-1];
          sr_q <= a_in[N-1];
`endif
          if (b_in == '0) begin
            state_q <= RESULT;
            quotient <= '1;
            remainder <= a_in;
            div_by_zero <= 1'b1;
            done <= 1'b1;
          end else state_q <= ITER;
        end
        ITER: begin
          r_q <= r_d;
          q_q <= q_d;
          dvd_q <= dvd_q << 2;
          cnt_q <= cnt_q + 1'b1;
          // Results are registered on the last iteration edge so done lands in RESULT.
          if (cnt_q == CW'(N/2-1)) begin
            state_q <= RESULT;
            quotient <= res_q;
            remainder <= res_r;
            div_by_zero <= 1'b0;
            done <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
